// File: rtl/sspi_wb2reg_bridge.sv
// Wishbone classic slave to SSPI register-bus master bridge.
// One WB cycle becomes one reg_cs/reg_ack access; a watchdog ends hung accesses with wbs_err_o.
module sspi_wb2reg_bridge #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned TO_CYC = 64
) (
   input  logic              app_clk,
   input  logic              reset,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic              wbs_we_i,
   input  logic [31:0]       wbs_dat_i,
   input  logic [3:0]        wbs_sel_i,
   output logic [31:0]       wbs_dat_o,
   output logic              wbs_ack_o,
   output logic              wbs_err_o,
   output logic              reg_cs,
   output logic              reg_wr,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [31:0]       reg_wdata,
   output logic [3:0]        reg_be,
   input  logic [31:0]       reg_rdata,
   input  logic              reg_ack
);

   localparam int unsigned TW = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TO_CYC - 1);

   typedef enum logic [1:0] {StIdle, StReq, StResp, StErr} state_e;

   state_e              r_state;
   logic [TW-1:0]       r_timer;
   logic                r_live;
   logic                r_cs;
   logic                r_wr;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [3:0]          r_be;
   logic [31:0]         r_dat;
   logic                r_ack;
   logic                r_err;

   logic                w_live;
   logic                w_unused;

   // An access whose WB cycle was abandoned still completes on the reg bus, silently.
   assign w_live   = r_live & wbs_cyc_i;
   assign w_unused = ^wbs_adr_i[31:ADDR_W];

   always_ff @(posedge app_clk) begin
      if (reset) begin
         r_state <= StIdle;
         r_timer <= '0;
         r_live  <= 1'b0;
         r_cs    <= 1'b0;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_dat   <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         r_dat <= '0;
         unique case (r_state)
            StIdle: begin
               if (wbs_cyc_i && wbs_stb_i) begin
                  r_state <= StReq;
                  r_timer <= '0;
                  r_live  <= 1'b1;
                  r_cs    <= 1'b1;
                  r_wr    <= wbs_we_i;
                  r_addr  <= wbs_adr_i[ADDR_W-1:0];
                  r_wdata <= wbs_dat_i;
                  r_be    <= wbs_sel_i;
               end
            end
            StReq: begin
               r_live <= w_live;
               // reg_ack on the timeout cycle takes priority over the error.
               if (reg_ack) begin
                  r_state <= StResp;
                  r_ack   <= w_live;
                  r_dat   <= (w_live && !r_wr) ? reg_rdata : 32'h0;
               end else if (r_timer == TMAX) begin
                  r_state <= StErr;
                  r_err   <= w_live;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
               if (reg_ack || (r_timer == TMAX)) begin
                  r_timer <= '0;
                  r_cs    <= 1'b0;
                  r_wr    <= 1'b0;
                  r_addr  <= '0;
                  r_wdata <= '0;
                  r_be    <= '0;
               end
            end
            StResp: r_state <= StIdle;
            StErr:  r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
      end
   end

   assign wbs_dat_o = r_dat;
   assign wbs_ack_o = r_ack;
   assign wbs_err_o = r_err;
   assign reg_cs    = r_cs;
   assign reg_wr    = r_wr;
   assign reg_addr  = r_addr;
   assign reg_wdata = r_wdata;
   assign reg_be    = r_be;

endmodule

// File: tb/tb_sspi_wb2reg_bridge.sv
// Directed self-checking bench for sspi_wb2reg_bridge (ADDR_W=11, TO_CYC=64).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sspi_wb2reg_bridge;

   logic        app_clk = 1'b0;
   logic        reset;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_ack_o, wbs_err_o;
   logic        reg_cs, reg_wr;
   logic [10:0] reg_addr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_be;
   logic [31:0] reg_rdata;
   logic        reg_ack;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 app_clk = ~app_clk;

   sspi_wb2reg_bridge #(.ADDR_W(11), .TO_CYC(64)) dut (
      .app_clk   (app_clk),
      .reset     (reset),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_dat_o (wbs_dat_o),
      .wbs_ack_o (wbs_ack_o),
      .wbs_err_o (wbs_err_o),
      .reg_cs    (reg_cs),
      .reg_wr    (reg_wr),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_be    (reg_be),
      .reg_rdata (reg_rdata),
      .reg_ack   (reg_ack)
   );

   task automatic bus_idle();
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      wbs_adr_i = 32'h0;
      wbs_dat_i = 32'h0;
      wbs_sel_i = 4'h0;
   endtask

   task automatic bus_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = we;
      wbs_adr_i = adr;
      wbs_dat_i = dat;
      wbs_sel_i = sel;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus_idle();
      reg_ack   = 1'b0;
      reg_rdata = 32'h0;
      repeat (3) @(negedge app_clk);
      n_cmp++;
      if ({reg_cs, reg_wr, wbs_ack_o, wbs_err_o} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b want 0000", {reg_cs, reg_wr, wbs_ack_o, wbs_err_o});
      end
      n_cmp++;
      if ({reg_addr, reg_wdata, reg_be, wbs_dat_o} !== 79'h0) begin
         n_bad++;
         $display("FAIL reset_data: got %h want 0", {reg_addr, reg_wdata, reg_be, wbs_dat_o});
      end
      reset = 1'b0;
   endtask

   task automatic test_write();
      @(negedge app_clk);
      bus_req(1'b1, 32'h0000_0044, 32'hA5A5_1234, 4'hF);
      for (int c = 1; c <= 2; c++) begin
         @(negedge app_clk);
         n_cmp++;
         if ({reg_cs, reg_wr, reg_addr, reg_be, reg_wdata, wbs_ack_o} !==
             {1'b1, 1'b1, 11'h044, 4'hF, 32'hA5A5_1234, 1'b0}) begin
            n_bad++;
            $display("FAIL wr_held c%0d: got cs=%b wr=%b a=%h be=%h d=%h ack=%b want 1 1 044 f a5a51234 0",
                     c, reg_cs, reg_wr, reg_addr, reg_be, reg_wdata, wbs_ack_o);
         end
      end
      reg_ack = 1'b1;
      @(negedge app_clk);
      reg_ack = 1'b0;
      n_cmp++;
      if ({wbs_ack_o, wbs_err_o, reg_cs, wbs_dat_o} !== {3'b100, 32'h0}) begin
         n_bad++;
         $display("FAIL wr_ack: got ack=%b err=%b cs=%b dat=%h want 1 0 0 0",
                  wbs_ack_o, wbs_err_o, reg_cs, wbs_dat_o);
      end
      bus_idle();
      @(negedge app_clk);
      n_cmp++;
      if (wbs_ack_o !== 1'b0) begin
         n_bad++;
         $display("FAIL wr_ack_pulse: got %b want 0", wbs_ack_o);
      end
   endtask

   task automatic test_read();
      @(negedge app_clk);
      bus_req(1'b0, 32'h0000_0048, 32'h0, 4'hF);
      @(negedge app_clk);
      n_cmp++;
      if ({reg_cs, reg_wr, reg_addr} !== {2'b10, 11'h048}) begin
         n_bad++;
         $display("FAIL rd_cs: got cs=%b wr=%b a=%h want 1 0 048", reg_cs, reg_wr, reg_addr);
      end
      reg_ack   = 1'b1;
      reg_rdata = 32'hCAFE_F00D;
      @(negedge app_clk);
      reg_ack   = 1'b0;
      reg_rdata = 32'h0;
      n_cmp++;
      if ({wbs_ack_o, wbs_dat_o} !== {1'b1, 32'hCAFE_F00D}) begin
         n_bad++;
         $display("FAIL rd_data: got ack=%b dat=%h want 1 cafef00d", wbs_ack_o, wbs_dat_o);
      end
      bus_idle();
      @(negedge app_clk);
      n_cmp++;
      if ({wbs_ack_o, wbs_dat_o} !== 33'h0) begin
         n_bad++;
         $display("FAIL rd_data_clear: got ack=%b dat=%h want 0 0", wbs_ack_o, wbs_dat_o);
      end
   endtask

   task automatic test_timeout();
      int cnt;
      int errs;
      cnt = 0;
      @(negedge app_clk);
      bus_req(1'b0, 32'h0000_0100, 32'h0, 4'hF);
      for (int i = 0; i < 100; i++) begin
         @(negedge app_clk);
         if (reg_cs) cnt++;
         else break;
      end
      n_cmp++;
      if (cnt !== 64) begin
         n_bad++;
         $display("FAIL to_cs_len: got %0d cycles want 64", cnt);
      end
      n_cmp++;
      if ({wbs_err_o, wbs_ack_o, wbs_dat_o} !== {2'b10, 32'h0}) begin
         n_bad++;
         $display("FAIL to_err: got err=%b ack=%b dat=%h want 1 0 0", wbs_err_o, wbs_ack_o, wbs_dat_o);
      end
      bus_idle();
      @(negedge app_clk);
      n_cmp++;
      if (wbs_err_o !== 1'b0) begin
         n_bad++;
         $display("FAIL to_err_pulse: got %b want 0", wbs_err_o);
      end
      repeat (3) @(negedge app_clk);
      reg_ack = 1'b1;
      @(negedge app_clk);
      reg_ack = 1'b0;
      errs = 0;
      for (int i = 0; i < 3; i++) begin
         if (wbs_ack_o || wbs_err_o || reg_cs) errs++;
         @(negedge app_clk);
      end
      n_cmp++;
      if (errs !== 0) begin
         n_bad++;
         $display("FAIL late_ack_ignored: got %0d active cycles want 0", errs);
      end
   endtask

   task automatic test_ack_on_timeout();
      @(negedge app_clk);
      bus_req(1'b0, 32'h0000_0200, 32'h0, 4'hF);
      repeat (64) @(negedge app_clk);
      n_cmp++;
      if (reg_cs !== 1'b1) begin
         n_bad++;
         $display("FAIL edge_cs64: got %b want 1", reg_cs);
      end
      reg_ack   = 1'b1;
      reg_rdata = 32'h1357_9BDF;
      @(negedge app_clk);
      reg_ack   = 1'b0;
      reg_rdata = 32'h0;
      n_cmp++;
      if ({wbs_ack_o, wbs_err_o, wbs_dat_o} !== {2'b10, 32'h1357_9BDF}) begin
         n_bad++;
         $display("FAIL edge_ack_wins: got ack=%b err=%b dat=%h want 1 0 13579bdf",
                  wbs_ack_o, wbs_err_o, wbs_dat_o);
      end
      bus_idle();
      @(negedge app_clk);
      n_cmp++;
      if ({wbs_ack_o, wbs_err_o} !== 2'b00) begin
         n_bad++;
         $display("FAIL edge_after: got ack=%b err=%b want 0 0", wbs_ack_o, wbs_err_o);
      end
   endtask

   task automatic test_reset_in_req();
      @(negedge app_clk);
      bus_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h3);
      @(negedge app_clk);
      reset = 1'b1;
      bus_idle();
      @(negedge app_clk);
      reset = 1'b0;
      n_cmp++;
      if ({reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, wbs_ack_o, wbs_err_o} !== 51'h0) begin
         n_bad++;
         $display("FAIL rst_req: got cs=%b wr=%b a=%h d=%h be=%h want all 0",
                  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be);
      end
      bus_req(1'b0, 32'hFFFF_F7FC, 32'h0, 4'hF);
      @(negedge app_clk);
      n_cmp++;
      if ({reg_cs, reg_addr} !== {1'b1, 11'h7FC}) begin
         n_bad++;
         $display("FAIL rst_new_cs: got cs=%b a=%h want 1 7fc", reg_cs, reg_addr);
      end
      reg_ack   = 1'b1;
      reg_rdata = 32'h0BAD_F00D;
      @(negedge app_clk);
      reg_ack   = 1'b0;
      reg_rdata = 32'h0;
      n_cmp++;
      if ({wbs_ack_o, wbs_dat_o} !== {1'b1, 32'h0BAD_F00D}) begin
         n_bad++;
         $display("FAIL rst_new_ack: got ack=%b dat=%h want 1 0badf00d", wbs_ack_o, wbs_dat_o);
      end
      bus_idle();
      @(negedge app_clk);
   endtask

   task automatic test_cyc_drop();
      @(negedge app_clk);
      bus_req(1'b0, 32'h0000_0020, 32'h0, 4'hF);
      @(negedge app_clk);
      bus_idle();
      @(negedge app_clk);
      n_cmp++;
      if (reg_cs !== 1'b1) begin
         n_bad++;
         $display("FAIL drop_cs_held: got %b want 1", reg_cs);
      end
      reg_ack   = 1'b1;
      reg_rdata = 32'h5555_AAAA;
      @(negedge app_clk);
      reg_ack   = 1'b0;
      reg_rdata = 32'h0;
      n_cmp++;
      if ({reg_cs, wbs_ack_o, wbs_err_o, wbs_dat_o} !== 35'h0) begin
         n_bad++;
         $display("FAIL drop_suppress: got cs=%b ack=%b err=%b dat=%h want 0 0 0 0",
                  reg_cs, wbs_ack_o, wbs_err_o, wbs_dat_o);
      end
      @(negedge app_clk);
   endtask

   task automatic test_back_to_back();
      @(negedge app_clk);
      reg_ack = 1'b1;
      bus_req(1'b1, 32'h0000_0060, 32'h1111_2222, 4'hC);
      @(negedge app_clk);
      n_cmp++;
      if ({reg_cs, reg_wr, reg_addr, reg_wdata, reg_be} !==
          {2'b11, 11'h060, 32'h1111_2222, 4'hC}) begin
         n_bad++;
         $display("FAIL b2b_first: got cs=%b a=%h d=%h be=%h want 1 060 11112222 c",
                  reg_cs, reg_addr, reg_wdata, reg_be);
      end
      @(negedge app_clk);
      n_cmp++;
      if ({wbs_ack_o, reg_cs} !== 2'b10) begin
         n_bad++;
         $display("FAIL b2b_ack1: got ack=%b cs=%b want 1 0", wbs_ack_o, reg_cs);
      end
      bus_req(1'b1, 32'h0000_0064, 32'h3333_4444, 4'h5);
      @(negedge app_clk);
      n_cmp++;
      if ({wbs_ack_o, reg_cs} !== 2'b00) begin
         n_bad++;
         $display("FAIL b2b_gap: got ack=%b cs=%b want 0 0", wbs_ack_o, reg_cs);
      end
      @(negedge app_clk);
      n_cmp++;
      if ({reg_cs, reg_wr, reg_addr, reg_wdata, reg_be} !==
          {2'b11, 11'h064, 32'h3333_4444, 4'h5}) begin
         n_bad++;
         $display("FAIL b2b_second: got cs=%b a=%h d=%h be=%h want 1 064 33334444 5",
                  reg_cs, reg_addr, reg_wdata, reg_be);
      end
      @(negedge app_clk);
      reg_ack = 1'b0;
      n_cmp++;
      if ({wbs_ack_o, wbs_err_o, reg_cs} !== 3'b100) begin
         n_bad++;
         $display("FAIL b2b_ack2: got ack=%b err=%b cs=%b want 1 0 0", wbs_ack_o, wbs_err_o, reg_cs);
      end
      bus_idle();
      @(negedge app_clk);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_ack_on_timeout();
      test_reset_in_req();
      test_cyc_drop();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
